bh_reg_arbiter: RTL

- Two-requester, round-robin controller that shares a WIDTH-bit register built from existing bh flip-flop cells.
- Each requester submits a bh command (toggle/set/clear/hold) with a bit mask.
- The arbiter grants one requester at a time and drives {B,H} into the masked cells for exactly one clock.
- It also initialises the cells on reset, since bh has no reset of its own.

---
 rtl/bh_pkg.sv | 26 ++
 rtl/bh_reg_arbiter_bh.sv | 21 ++
 rtl/bh_reg_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/bh_pkg.sv
// Shared definitions for the bh cell and the bh register arbiter:
// command encodings, FSM state encodings and the cell next-state function.
package bh_pkg;

  localparam logic [1:0] BH_TOGGLE = 2'b00;
  localparam logic [1:0] BH_SET    = 2'b01;
  localparam logic [1:0] BH_CLEAR  = 2'b10;
  localparam logic [1:0] BH_HOLD   = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_APPLY = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  function automatic logic bh_next(input logic cur, input logic [1:0] cmd);
    logic nxt;
    case (cmd)
      BH_TOGGLE: nxt = ~cur;
      BH_SET:    nxt = 1'b1;
      BH_CLEAR:  nxt = 1'b0;
      BH_HOLD:   nxt = cur;
      default:   nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bh_reg_arbiter_bh.sv
// Single bh flip-flop cell: {B,H} selects toggle/set/clear/hold.
// It has no reset; the owner initialises it by driving clear.
module bh
  import bh_pkg::*;
(
  input  logic clk,
  input  logic b,
  input  logic h,
  output logic q
);

  logic q_r;

  // cell state update from the {B,H} command
  always_ff @(posedge clk) begin
    q_r <= bh_next(q_r, {b, h});
  end

  assign q = q_r;

endmodule

// File: rtl/bh_reg_arbiter.sv
// Two-requester round-robin arbiter sharing a WIDTH-bit register of bh cells.
// A granted command is applied to the masked cells for exactly one clock.
module bh_reg_arbiter
  import bh_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] mask0,
  input  logic             req1,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] mask1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             z
);

  logic [1:0]       state_r;
  logic             last_gnt_r;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] mask_r;
  logic             gnt0_r;
  logic             gnt1_r;
  logic             done_r;
  logic             pick_s;
  logic [WIDTH-1:0] cell_b_s;
  logic [WIDTH-1:0] cell_h_s;
  logic [WIDTH-1:0] q_s;

  // round-robin pick: under contention the requester not served last wins
  always_comb begin
    pick_s = 1'b0;
    if (req0 && req1) begin
      pick_s = ~last_gnt_r;
    end else if (req1) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
  end

  // handshake FSM: IDLE latches the winner, APPLY drives cells, DONE pulses done
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      last_gnt_r <= 1'b1;
      op_r       <= BH_HOLD;
      mask_r     <= {WIDTH{1'b0}};
      gnt0_r     <= 1'b0;
      gnt1_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req0 || req1) begin
            state_r    <= ST_APPLY;
            last_gnt_r <= pick_s;
            op_r       <= pick_s ? op1 : op0;
            mask_r     <= pick_s ? mask1 : mask0;
            gnt0_r     <= ~pick_s;
            gnt1_r     <= pick_s;
          end
        end
        ST_APPLY: begin
          state_r <= ST_DONE;
          done_r  <= 1'b1;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          gnt0_r  <= 1'b0;
          gnt1_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          gnt0_r  <= 1'b0;
          gnt1_r  <= 1'b0;
        end
      endcase
    end
  end

  // per-cell {B,H}: reset forces clear, APPLY drives masked bits, else hold
  always_comb begin
    cell_b_s = {WIDTH{1'b1}};
    cell_h_s = {WIDTH{1'b1}};
    for (int i = 0; i < WIDTH; i++) begin
      if (rst) begin
        cell_b_s[i] = BH_CLEAR[1];
        cell_h_s[i] = BH_CLEAR[0];
      end else if ((state_r == ST_APPLY) && mask_r[i]) begin
        cell_b_s[i] = op_r[1];
        cell_h_s[i] = op_r[0];
      end else begin
        cell_b_s[i] = BH_HOLD[1];
        cell_h_s[i] = BH_HOLD[0];
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    bh u_bh (
      .clk (clk),
      .b   (cell_b_s[g]),
      .h   (cell_h_s[g]),
      .q   (q_s[g])
    );
  end

  assign gnt0 = gnt0_r;
  assign gnt1 = gnt1_r;
  assign done = done_r;
  assign q    = q_s;
  assign z    = (&q_s) | ~(|q_s);

endmodule
